// File: rtl/mul_ctrl_if.sv
// Handshake and strobe bundle between the multiplier controller and its host/datapath.
// The controller takes the slave modport; the host plus datapath take master.
interface mul_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic         ack;
  logic [W-1:0] cnt;
  logic         p_carry;
  logic         ldA;
  logic         ldB;
  logic         decB;
  logic         clrP;
  logic         ldP;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output start, ack, cnt, p_carry,
    input  ldA, ldB, decB, clrP, ldP, busy, done, ovf
  );

  modport slave (
    input  start, ack, cnt, p_carry,
    output ldA, ldB, decB, clrP, ldP, busy, done, ovf
  );
endinterface

// File: rtl/mul_ctrl.sv
// Control FSM for a repeated-addition multiplier: loads A and B over a shared bus,
// then adds A into the product once per remaining count until the down counter hits zero.
module mul_ctrl #(
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       rst,
  mul_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    ADD    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [W-1:0] CNT_ZERO = '0;
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   ldA_q, ldB_q, decB_q, clrP_q, ldP_q, busy_q, done_q, ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = CHECK;
      CHECK:   state_d = (bus.cnt == CNT_ZERO) ? DONE : ADD;
      // The decrement issued in this cycle takes the counter from 1 to 0.
      ADD:     if (bus.cnt == CNT_ONE) state_d = DONE;
      DONE:    if (bus.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ldA_q   <= 1'b0;
      ldB_q   <= 1'b0;
      decB_q  <= 1'b0;
      clrP_q  <= 1'b0;
      ldP_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ldA_q   <= (state_d == LOAD_A);
      ldB_q   <= (state_d == LOAD_B);
      clrP_q  <= (state_d == LOAD_B);
      decB_q  <= (state_d == ADD);
      ldP_q   <= (state_d == ADD);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (state_q == LOAD_B) begin
        ovf_q <= 1'b0;
      end else if (state_q == ADD && bus.p_carry) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.ldA  = ldA_q;
  assign bus.ldB  = ldB_q;
  assign bus.decB = decB_q;
  assign bus.clrP = clrP_q;
  assign bus.ldP  = ldP_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: a small datapath (A register, product adder, down counter) around the
// controller, with each operation checked against plain multiplication and cycle-count rules.
module tb_mul_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_ctrl_if #(.W(W)) bus ();

  mul_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath around the controller
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] din;
  logic [W-1:0] a_reg = '0, p_reg = '0, cnt_reg = '0;
  logic [W:0]   sum;

  assign din         = bus.ldA ? op_a : (bus.ldB ? op_b : '0);
  assign sum         = {1'b0, p_reg} + {1'b0, a_reg};
  assign bus.p_carry = sum[W];
  assign bus.cnt     = cnt_reg;

  always @(posedge clk) begin
    if (bus.ldA) a_reg <= din;
    if (bus.ldB) cnt_reg <= din;
    else if (bus.decB) cnt_reg <= cnt_reg - 1'b1;
    if (bus.clrP) p_reg <= '0;
    else if (bus.ldP) p_reg <= sum[W-1:0];
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] outs();
    return {bus.ldA, bus.ldB, bus.decB, bus.clrP, bus.ldP, bus.busy, bus.done, bus.ovf};
  endfunction

  // One complete operation: start pulse, run to done, hold done, then acknowledge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit start_in_done);
    logic [2*W-1:0] full;
    logic [W-1:0]   exp_p;
    logic           exp_ovf;
    int k, done_k, n_ldp, overlap, hold_bad;
    full    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    exp_p   = full[W-1:0];
    exp_ovf = (full[2*W-1:W] != '0);
    op_a = a;
    op_b = b;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 0; done_k = -1; n_ldp = 0; overlap = 0;
    while (done_k < 0 && k <= int'(b) + 10) begin
      if (k == 0) begin
        total++;
        if (bus.ldA !== 1'b1) begin bad++; $display("FAIL ldA_first: got %b want 1", bus.ldA); end
      end
      if (k == 1) begin
        total++;
        if ({bus.ldB, bus.clrP} !== 2'b11) begin
          bad++; $display("FAIL ldB_clrP: got %b want 11", {bus.ldB, bus.clrP});
        end
      end
      if (k == 2) begin
        total++;
        if (bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", bus.ovf); end
      end
      if (bus.ldP === 1'b1) n_ldp++;
      if (bus.ldB === 1'b1 && bus.decB === 1'b1) overlap++;
      if (bus.done === 1'b1) done_k = k;
      else begin @(negedge clk); k++; end
    end
    total++;
    if (done_k != 3 + int'(b)) begin bad++; $display("FAIL latency: got %0d want %0d", done_k, 3 + int'(b)); end
    total++;
    if (n_ldp != int'(b)) begin bad++; $display("FAIL add_cycles: got %0d want %0d", n_ldp, int'(b)); end
    total++;
    if (overlap != 0) begin bad++; $display("FAIL ld_dec_overlap: got %0d want 0", overlap); end
    total++;
    if (p_reg !== exp_p) begin bad++; $display("FAIL product: got %h want %h", p_reg, exp_p); end
    total++;
    if (bus.ovf !== exp_ovf) begin bad++; $display("FAIL ovf_done: got %b want %b", bus.ovf, exp_ovf); end
    total++;
    if (cnt_reg !== '0) begin bad++; $display("FAIL cnt_end: got %h want 0", cnt_reg); end
    hold_bad = 0;
    for (int i = 1; i < hold; i++) begin
      bus.start = start_in_done && (i == 2);
      @(negedge clk);
      if (bus.done !== 1'b1 || bus.busy !== 1'b1) hold_bad++;
    end
    bus.start = 1'b0;
    total++;
    if (hold_bad != 0) begin bad++; $display("FAIL done_hold: got %0d drops want 0", hold_bad); end
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.ovf} !== {2'b00, exp_ovf}) begin
      bad++; $display("FAIL ack_idle: got busy/done/ovf=%b want %b", {bus.busy, bus.done, bus.ovf}, {2'b00, exp_ovf});
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_stay: got busy=%b want 0", bus.busy); end
    $display("op A=%h B=%h P=%h ovf=%b latency=%0d hold=%0d", a, b, p_reg, bus.ovf, done_k, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.ack = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== 8'h00) begin bad++; $display("FAIL reset_outs: got %b want 00000000", outs()); end
    rst = 1'b0; bus.start = 1'b0; bus.ack = 1'b0;
    @(negedge clk);
    total++;
    if (outs() !== 8'h00) begin bad++; $display("FAIL reset_idle: got %b want 00000000", outs()); end
    $display("reset outs=%b", outs());
  endtask

  task automatic test_basic();
    run_op(16'd5, 16'd3, 1, 1'b0);
    run_op(16'd9, 16'd0, 2, 1'b0);
  endtask

  task automatic test_done_hold();
    run_op(16'd6, 16'd1, 10, 1'b1);
  endtask

  task automatic test_overflow();
    run_op(16'h8000, 16'd2, 1, 1'b0);
    run_op(16'd2, 16'd2, 1, 1'b0);
  endtask

  task automatic test_mid_reset();
    op_a = 16'd7; op_b = 16'd5;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus.ldP !== 1'b1) begin bad++; $display("FAIL mid_add: got ldP=%b want 1", bus.ldP); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (outs() !== 8'h00) begin bad++; $display("FAIL mid_reset: got %b want 00000000", outs()); end
    $display("mid-reset outs=%b", outs());
    run_op(16'd3, 16'd4, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_op(W'($urandom), W'($urandom_range(0, 12)), int'($urandom_range(1, 3)), 1'b0);
    end
  endtask

  task automatic test_max_count();
    run_op(16'd0, 16'hFFFF, 1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ack = 1'b0;
    test_reset();
    test_basic();
    test_done_hold();
    test_overflow();
    test_mid_reset();
    test_random();
    test_max_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Control FSM for the repeated-addition multiplier datapath. It sequences operand loading over the shared `din` bus, drives the load and decrement strobes of the operand-B down counter, the operand-A register and the product accumulator, and detects termination from the counter's output value. It sits directly upstream of the down counter: it produces that counter's `ld`/`dec` and consumes its `dout`. It also provides a start/done/ack handshake and a sticky overflow flag to the host.

## Interface
- `W`, default 16: width of the counter value (`cnt`) input.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply; sampled only in IDLE.
- `ack` input 1: host acknowledge of `done`; sampled only in DONE.
- `cnt` input W: down-counter `dout` (current remaining multiplier value).
- `p_carry` input 1: carry-out of the product adder for the current cycle.
- `ldA` output 1: load operand-A register from `din`.
- `ldB` output 1: drives counter `ld` (load B from `din`).
- `decB` output 1: drives counter `dec`.
- `clrP` output 1: clear product accumulator.
- `ldP` output 1: load accumulator with accumulator + A.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: high only in DONE.
- `ovf` output 1: sticky overflow flag for the current operation.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CHECK, ADD, DONE. Moore outputs decoded from the state register. `ovf` is a separate register.
- IDLE: all strobes 0. `start`=1 -> LOAD_A; otherwise stay.
- LOAD_A: `ldA`=1; host drives A on `din` this cycle. -> LOAD_B unconditionally.
- LOAD_B: `ldB`=1, `clrP`=1; host drives B on `din` this cycle. Clear `ovf`. -> CHECK.
- CHECK: no strobes. `cnt`==0 -> DONE, otherwise -> ADD.
- ADD: `ldP`=1, `decB`=1 every cycle.
  - `cnt`==1 -> DONE; this cycle's decrement leaves the counter at 0.
  - Otherwise stay in ADD.
  - Exactly B ADD cycles are executed per operation.
- DONE: `done`=1, `busy`=1. `ack`=1 -> IDLE; otherwise hold. The counter holds 0 and the product holds its value while waiting.
- `ovf`:
  - Set when `p_carry`=1 in an ADD cycle.
  - Held through DONE and IDLE.
  - Cleared only in LOAD_B or by `rst`.
  - `p_carry` is ignored outside ADD.
- `start` outside IDLE is ignored; it is not queued.
- `ack` outside DONE is ignored.
- `ldB` and `decB` are never asserted in the same cycle, so the counter's ld-over-dec priority is never exercised.
- `cnt` is compared unsigned. Its full W-bit value is used, so B = 2^W−1 is legal and takes 2^W−1 ADD cycles.

## Timing
- Reset: `rst`=1 at a clock edge forces IDLE and `ovf`=0 on that edge. Reset overrides `start` and `ack` in the same cycle.
- Outputs after reset: `ldA`=`ldB`=`decB`=`clrP`=`ldP`=`busy`=`done`=`ovf`=0.
- Reset mid-operation (any state) aborts immediately. The datapath registers are left as-is; the next LOAD_B reinitialises them.
- `start` sampled high in IDLE at edge t: LOAD_A during t..t+1, LOAD_B during t+1..t+2, CHECK during t+2..t+3.
- First ADD cycle is during t+3..t+4. DONE is entered at edge t+3+B for B>0, and at edge t+3 for B=0.
- Latency from the `start` edge to `done` high: 3+B cycles (3 for B=0).
- `done` falls on the edge after `ack` is sampled high. `start` can be accepted one cycle later from IDLE.
- `cnt` must reflect the counter's registered output. No combinational path from `cnt` to any output; only the next-state logic depends on it.

## Test plan
- A=5, B=3, start pulse at edge t: `ldA` at cycle t, `ldB`+`clrP` at t+1, `ldP`/`decB` high for exactly 3 cycles, `done` at t+6. Product=15, `ovf`=0.
- B=0: no `ldP` or `decB` pulses; `done` 3 cycles after start. Product=0.
- B=1, then hold `ack` low for 10 cycles: one `ldP`, `done` stays high 10 cycles. `ack`=1 returns to IDLE and `busy` drops; a `start` pulsed during DONE is ignored.
- W=16, A=0x8000, B=2 with `p_carry` modelled from the adder: `ovf`=1 at `done`. A following run with A=2, B=2 clears `ovf` at LOAD_B and ends with `ovf`=0.
- Assert `rst` in the second ADD cycle of A=7, B=5: all outputs 0 on the next edge, state IDLE. A new start with A=3, B=4 yields product 12 in 7 cycles.
- B=0xFFFF with A=0: exactly 65535 ADD cycles, `done` at start+65538, counter ends at 0, and `ldB`/`decB` are never both high.
